// File: rtl/rob_retire_unit_pkg.sv
// Shared types and default sizes for the reorder buffer and its commit selector.
// Entry widths follow the default data/register/tag widths below.
package rob_pkg;
    localparam int DATA_MSB     = 31;
    localparam int REG_MSB      = 4;
    localparam int TAG_MSB      = 2;
    localparam int DEPTH_DEF    = 8;
    localparam int COMMIT_W_DEF = 2;

    typedef logic [TAG_MSB:0] rob_tag_t;

    typedef struct packed {
        logic                ready;
        logic                mispredict;
        logic                isBranch;
        logic [REG_MSB:0]    dest;
        logic [DATA_MSB:0]   value;
        logic [DATA_MSB:0]   target;
    } rob_entry_t;

    // Tag arithmetic wraps naturally modulo DEPTH because DEPTH is a power of two.
    function automatic rob_tag_t tag_add(rob_tag_t t, int unsigned n);
        return t + rob_tag_t'(n);
    endfunction
endpackage

// File: rtl/rob_retire_unit_if.sv
// Dispatch, CDB, operand-read and retire signals of the reorder buffer.
// slave = the buffer itself, master = the surrounding pipeline.
interface rob_retire_unit_if
    import rob_pkg::*;
#(
    parameter int WIDTH    = DATA_MSB,
    parameter int ROB      = TAG_MSB,
    parameter int COMMIT_W = COMMIT_W_DEF,
    parameter int REG      = REG_MSB
);
    logic                          alloc_valid;
    logic [REG:0]                  alloc_dest;
    logic                          alloc_isBranch;
    logic                          alloc_ready;
    logic [ROB:0]                  alloc_tag;

    logic                          cdb_valid;
    logic [ROB:0]                  cdb_tag;
    logic [WIDTH:0]                cdb_result;
    logic                          cdb_mispredict;
    logic [WIDTH:0]                cdb_target;

    logic [ROB:0]                  rob1;
    logic [ROB:0]                  rob2;
    logic [WIDTH:0]                ROBValue1;
    logic [WIDTH:0]                ROBValue2;
    logic                          valid1;
    logic                          valid2;

    logic [COMMIT_W-1:0]           commit_valid;
    logic [COMMIT_W*(REG+1)-1:0]   commit_dest;
    logic [COMMIT_W*(WIDTH+1)-1:0] commit_value;
    logic [COMMIT_W*(ROB+1)-1:0]   commit_tag;
    logic                          flush;
    logic [WIDTH:0]                flush_pc;

    modport slave (
        input  alloc_valid, alloc_dest, alloc_isBranch,
        input  cdb_valid, cdb_tag, cdb_result, cdb_mispredict, cdb_target,
        input  rob1, rob2,
        output alloc_ready, alloc_tag,
        output ROBValue1, ROBValue2, valid1, valid2,
        output commit_valid, commit_dest, commit_value, commit_tag,
        output flush, flush_pc
    );

    modport master (
        output alloc_valid, alloc_dest, alloc_isBranch,
        output cdb_valid, cdb_tag, cdb_result, cdb_mispredict, cdb_target,
        output rob1, rob2,
        input  alloc_ready, alloc_tag,
        input  ROBValue1, ROBValue2, valid1, valid2,
        input  commit_valid, commit_dest, commit_value, commit_tag,
        input  flush, flush_pc
    );
endinterface

// File: rtl/rob_retire_unit_commit_select.sv
// In-order retire priority chain over the COMMIT_W entries starting at head; purely combinational.
// A lane stops the chain when not ready, and the first mispredicted branch lane retires and raises flush.
module commit_select
    import rob_pkg::*;
#(
    parameter int COMMIT_W = COMMIT_W_DEF,
    parameter int WIDTH    = DATA_MSB,
    parameter int CNT_W    = 4
) (
    input  logic [COMMIT_W-1:0]            lane_ok,
    input  logic [COMMIT_W-1:0]            lane_misp,
    input  logic [COMMIT_W-1:0][WIDTH:0]   lane_target,
    output logic [COMMIT_W-1:0]            lane_vld,
    output logic [CNT_W-1:0]               n_ret,
    output logic                           flush,
    output logic [WIDTH:0]                 flush_pc
);
    logic alive;

    always_comb begin
        lane_vld = '0;
        n_ret    = '0;
        flush    = 1'b0;
        flush_pc = '0;
        alive    = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            lane_vld[i] = alive && lane_ok[i];
            if (lane_vld[i]) begin
                n_ret = n_ret + CNT_W'(1);
            end
            if (lane_vld[i] && lane_misp[i]) begin
                flush    = 1'b1;
                flush_pc = lane_target[i];
            end
            alive = lane_vld[i] && !lane_misp[i];
        end
    end
endmodule

// File: rtl/rob_retire_unit.sv
// Circular reorder buffer: one allocation per cycle, CDB capture, two operand reads, COMMIT_W-wide in-order retire.
// Retire outputs are combinational from registered state; alloc_ready backpressures dispatch when full or flushing.
module rob_retire_unit
    import rob_pkg::*;
#(
    parameter int WIDTH    = DATA_MSB,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ROB      = TAG_MSB,
    parameter int COMMIT_W = COMMIT_W_DEF,
    parameter int REG      = REG_MSB
) (
    input  logic             clk,
    input  logic             reset,
    rob_retire_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rob_entry_t                    ent [DEPTH];
    logic [ROB:0]                  head;
    logic [ROB:0]                  tail;
    logic [CNT_W-1:0]              count;

    logic [COMMIT_W-1:0][ROB:0]    lane_tag;
    logic [COMMIT_W-1:0]           lane_ok;
    logic [COMMIT_W-1:0]           lane_misp;
    logic [COMMIT_W-1:0][WIDTH:0]  lane_target;
    logic [COMMIT_W-1:0]           lane_vld;
    logic [CNT_W-1:0]              n_ret;
    logic                          do_flush;
    logic [WIDTH:0]                flush_tgt;
    logic                          do_alloc;
    logic                          cdb_hit;
    logic [ROB:0]                  cdb_off;

    // Only registered ready bits feed retirement, so a CDB write never retires in its own cycle.
    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            lane_tag[i]    = tag_add(head, i);
            lane_ok[i]     = (CNT_W'(i) < count) && ent[lane_tag[i]].ready;
            lane_misp[i]   = ent[lane_tag[i]].mispredict && ent[lane_tag[i]].isBranch;
            lane_target[i] = ent[lane_tag[i]].target;
        end
    end

    commit_select #(
        .COMMIT_W (COMMIT_W),
        .WIDTH    (WIDTH),
        .CNT_W    (CNT_W)
    ) u_sel (
        .lane_ok     (lane_ok),
        .lane_misp   (lane_misp),
        .lane_target (lane_target),
        .lane_vld    (lane_vld),
        .n_ret       (n_ret),
        .flush       (do_flush),
        .flush_pc    (flush_tgt)
    );

    // A tag is live when its distance from head is below the occupancy count.
    assign cdb_off         = bus.cdb_tag - head;
    assign cdb_hit         = bus.cdb_valid && (CNT_W'(cdb_off) < count);
    assign bus.alloc_ready = (count != CNT_W'(DEPTH)) && !do_flush;
    assign do_alloc        = bus.alloc_valid && bus.alloc_ready;
    assign bus.alloc_tag   = tail;
    assign bus.flush       = do_flush;
    assign bus.flush_pc    = flush_tgt;
    assign bus.commit_valid = lane_vld;

    always_comb begin
        bus.commit_dest  = '0;
        bus.commit_value = '0;
        bus.commit_tag   = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            bus.commit_dest[i*(REG+1) +: (REG+1)]       = ent[lane_tag[i]].dest;
            bus.commit_value[i*(WIDTH+1) +: (WIDTH+1)]  = ent[lane_tag[i]].value;
            bus.commit_tag[i*(ROB+1) +: (ROB+1)]        = lane_tag[i];
        end
    end

    always_comb begin
        bus.valid1    = ent[bus.rob1].ready;
        bus.ROBValue1 = ent[bus.rob1].value;
        bus.valid2    = ent[bus.rob2].ready;
        bus.ROBValue2 = ent[bus.rob2].value;
        if (bus.cdb_valid && (bus.cdb_tag == bus.rob1)) begin
            bus.valid1    = 1'b1;
            bus.ROBValue1 = bus.cdb_result;
        end
        if (bus.cdb_valid && (bus.cdb_tag == bus.rob2)) begin
            bus.valid2    = 1'b1;
            bus.ROBValue2 = bus.cdb_result;
        end
    end

    // Ready is cleared on retire so a stale tag never reports a value on the read ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (do_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].ready      <= 1'b0;
                ent[i].mispredict <= 1'b0;
            end
        end else begin
            if (cdb_hit) begin
                ent[bus.cdb_tag].ready      <= 1'b1;
                ent[bus.cdb_tag].value      <= bus.cdb_result;
                ent[bus.cdb_tag].mispredict <= bus.cdb_mispredict;
                ent[bus.cdb_tag].target     <= bus.cdb_target;
            end
            for (int i = 0; i < COMMIT_W; i++) begin
                if (lane_vld[i]) begin
                    ent[lane_tag[i]].ready <= 1'b0;
                end
            end
            if (do_alloc) begin
                ent[tail] <= rob_entry_t'{
                    ready:      1'b0,
                    mispredict: 1'b0,
                    isBranch:   bus.alloc_isBranch,
                    dest:       bus.alloc_dest,
                    value:      '0,
                    target:     '0
                };
            end
            head  <= head + (ROB+1)'(n_ret);
            tail  <= tail + (ROB+1)'(do_alloc);
            count <= count + CNT_W'(do_alloc) - n_ret;
        end
    end
endmodule

// File: tb/tb_rob_retire_unit.sv
// Directed and random stimulus against a queue-based program-order model of the reorder buffer.
module tb_rob_retire_unit;
    localparam int WIDTH = 31;
    localparam int DEPTH = 8;
    localparam int ROB   = 2;
    localparam int CW    = 2;
    localparam int REG   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rob_retire_unit_if #(.WIDTH(WIDTH), .ROB(ROB), .COMMIT_W(CW), .REG(REG)) bus ();

    rob_retire_unit #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ROB(ROB), .COMMIT_W(CW), .REG(REG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          tag;
        int          dest;
        bit          br;
        bit          rdy;
        bit          misp;
        logic [31:0] val;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int   mtail;
    int   total = 0;
    int   bad = 0;
    int   dut_commits = 0;
    int   model_commits = 0;

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(bit av, int dest, bit br, bit cv, int ctag,
                         logic [31:0] cres, bit cmis, logic [31:0] ctgt);
        bus.alloc_valid    = av;
        bus.alloc_dest     = 5'(dest);
        bus.alloc_isBranch = br;
        bus.cdb_valid      = cv;
        bus.cdb_tag        = 3'(ctag);
        bus.cdb_result     = cres;
        bus.cdb_mispredict = cmis;
        bus.cdb_target     = ctgt;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic rd_exp(int tag, output bit v, output logic [31:0] val);
        v = 0;
        val = '0;
        if (bus.cdb_valid && int'(bus.cdb_tag) == tag) begin
            v = 1;
            val = bus.cdb_result;
        end else begin
            foreach (q[k]) begin
                if (q[k].tag == tag && q[k].rdy) begin
                    v = 1;
                    val = q[k].val;
                end
            end
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        logic [CW-1:0] ecv;
        logic [31:0]   epc;
        logic [31:0]   val;
        bit            v;
        bit            efl;
        bit            do_al;
        int            nret;
        ent_t          e;
        @(negedge clk);
        ecv = '0; epc = '0; efl = 0; nret = 0;
        for (int i = 0; i < CW && i < q.size(); i++) begin
            if (!q[i].rdy) break;
            ecv[i] = 1'b1;
            nret++;
            chk("commit_dest", 64'(bus.commit_dest[i*(REG+1) +: (REG+1)]), 64'(q[i].dest));
            chk("commit_value", 64'(bus.commit_value[i*(WIDTH+1) +: (WIDTH+1)]), 64'(q[i].val));
            chk("commit_tag", 64'(bus.commit_tag[i*(ROB+1) +: (ROB+1)]), 64'(q[i].tag));
            if (q[i].br && q[i].misp) begin
                efl = 1;
                epc = q[i].tgt;
                break;
            end
        end
        chk("commit_valid", 64'(bus.commit_valid), 64'(ecv));
        chk("flush", 64'(bus.flush), 64'(efl));
        chk("flush_pc", 64'(bus.flush_pc), 64'(epc));
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(q.size() < DEPTH && !efl));
        chk("alloc_tag", 64'(bus.alloc_tag), 64'(mtail));
        rd_exp(int'(bus.rob1), v, val);
        chk("valid1", 64'(bus.valid1), 64'(v));
        if (v) chk("ROBValue1", 64'(bus.ROBValue1), 64'(val));
        rd_exp(int'(bus.rob2), v, val);
        chk("valid2", 64'(bus.valid2), 64'(v));
        if (v) chk("ROBValue2", 64'(bus.ROBValue2), 64'(val));
        for (int i = 0; i < CW; i++) dut_commits += int'(bus.commit_valid[i]);
        model_commits += nret;
        do_al = bus.alloc_valid && q.size() < DEPTH;
        @(posedge clk);
        if (efl) begin
            q.delete();
            mtail = 0;
        end else begin
            if (bus.cdb_valid) begin
                foreach (q[k]) begin
                    if (q[k].tag == int'(bus.cdb_tag)) begin
                        q[k].rdy  = 1;
                        q[k].val  = bus.cdb_result;
                        q[k].misp = bus.cdb_mispredict;
                        q[k].tgt  = bus.cdb_target;
                    end
                end
            end
            repeat (nret) void'(q.pop_front());
            if (do_al) begin
                e.tag = mtail; e.dest = int'(bus.alloc_dest); e.br = bus.alloc_isBranch;
                e.rdy = 0; e.misp = 0; e.val = '0; e.tgt = '0;
                q.push_back(e);
                mtail = (mtail + 1) % DEPTH;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #2;
        chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        chk("rst_alloc_tag", 64'(bus.alloc_tag), 64'd0);
        chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
        chk("rst_flush", 64'(bus.flush), 64'd0);
        chk("rst_flush_pc", 64'(bus.flush_pc), 64'd0);
        chk("rst_valid1", 64'(bus.valid1), 64'd0);
        chk("rst_valid2", 64'(bus.valid2), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        mtail = 0;
    endtask

    initial begin
        int base;
        int k;
        reset = 1'b1;
        bus.rob1 = '0;
        bus.rob2 = '0;
        idle();
        mtail = 0;
        #1;
        do_reset();

        // Fill all eight entries, then a ninth request that must be refused.
        for (int i = 0; i < 9; i++) begin
            drive(1, i + 1, 0, 0, 0, 32'h0, 0, 32'h0);
            tick();
        end
        idle();
        tick();
        do_reset();

        // Completion out of order: tags 2, 1, 0 on successive cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1, i + 5, 0, 0, 0, 32'h0, 0, 32'h0);
            tick();
        end
        for (int t = 2; t >= 0; t--) begin
            drive(0, 0, 0, 1, t, 32'h100 + 32'(t), 0, 32'h0);
            tick();
        end
        idle();
        repeat (3) tick();

        // Mispredicted branch behind a ready entry; an allocation in the flush cycle is dropped.
        do_reset();
        drive(1, 3, 0, 0, 0, 32'h0, 0, 32'h0); tick();
        drive(1, 0, 1, 0, 0, 32'h0, 0, 32'h0); tick();
        drive(0, 0, 0, 1, 0, 32'h11, 0, 32'h0); tick();
        drive(0, 0, 0, 1, 1, 32'h22, 1, 32'h0000_0400); tick();
        drive(1, 7, 0, 0, 0, 32'h0, 0, 32'h0); tick();
        idle(); tick();
        tick();

        // CDB bypass onto a read port, then the stored value on the other port.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, i + 1, 0, 0, 0, 32'h0, 0, 32'h0);
            tick();
        end
        bus.rob1 = 3'd3;
        drive(0, 0, 0, 1, 3, 32'hDEAD_BEEF, 0, 32'h0);
        tick();
        bus.rob1 = 3'd0;
        bus.rob2 = 3'd3;
        idle();
        tick();

        // Wrap: twenty allocate/complete pairs.
        do_reset();
        base = dut_commits;
        for (int i = 0; i < 21; i++) begin
            drive(i < 20, (i % 31) + 1, 0, i > 0, (i + 7) % 8, 32'(i * 3 + 1), 0, 32'h0);
            tick();
        end
        idle();
        repeat (4) tick();
        chk("wrap_commits", 64'(dut_commits - base), 64'd20);

        // Random traffic with an occasional mispredict and one reset in the middle.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            drive($urandom_range(2, 0) != 0, int'($urandom_range(31, 0)), $urandom_range(3, 0) == 0,
                  0, 0, 32'h0, 0, 32'h0);
            if (q.size() > 0 && $urandom_range(3, 0) != 0) begin
                k = int'($urandom_range(q.size() - 1, 0));
                if (!q[k].rdy) begin
                    bus.cdb_valid      = 1'b1;
                    bus.cdb_tag        = 3'(q[k].tag);
                    bus.cdb_result     = $urandom;
                    bus.cdb_mispredict = q[k].br && ($urandom_range(5, 0) == 0);
                    bus.cdb_target     = $urandom;
                end
            end else if ($urandom_range(7, 0) == 0) begin
                bus.cdb_valid  = 1'b1;
                bus.cdb_tag    = 3'($urandom_range(7, 0));
                bus.cdb_result = $urandom;
            end
            bus.rob1 = 3'($urandom_range(7, 0));
            bus.rob2 = 3'($urandom_range(7, 0));
            tick();
        end
        chk("total_commits", 64'(dut_commits), 64'(model_commits));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rob_retire_unit.md
# rob_retire_unit

Parametrised reorder buffer with N-wide in-order retirement for the out-of-order core. Allocates one entry per cycle from dispatch, captures results and branch outcomes from the common data bus, serves two operand-read ports to the reservation stations, and retires up to COMMIT_W consecutive completed entries per cycle toward the register file and register status table. A mispredicted branch at retirement triggers a full pipeline flush with redirect PC.

## Interface
Parameters:
- WIDTH, 31: data/address MSB (32-bit values)
- DEPTH, 8: ROB entries, power of two, ≥ 4
- ROB, 2: tag MSB, equals log2(DEPTH)-1
- COMMIT_W, 2: retire lanes, 1..4, ≤ DEPTH
- REG, 4: architectural register index MSB

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- alloc_valid  in  1  dispatch requests an entry
- alloc_dest  in  REG+1  destination register (0 = no writeback)
- alloc_isBranch  in  1  entry is a branch/jump
- alloc_ready  out  1  buffer not full
- alloc_tag  out  ROB+1  tag given to a successful allocation (current tail)
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  ROB+1  completing entry
- cdb_result  in  WIDTH+1  result value
- cdb_mispredict  in  1  branch resolved wrong
- cdb_target  in  WIDTH+1  correct next PC for mispredict
- rob1, rob2  in  ROB+1  operand-read tags
- ROBValue1, ROBValue2  out  WIDTH+1  entry values
- valid1, valid2  out  1  entry value ready
- commit_valid  out  COMMIT_W  per-lane retire strobe
- commit_dest  out  COMMIT_W*(REG+1)  per-lane destination register
- commit_value  out  COMMIT_W*(WIDTH+1)  per-lane value
- commit_tag  out  COMMIT_W*(ROB+1)  per-lane tag (register status clear)
- flush  out  1  mispredict retire, flush pipeline
- flush_pc  out  WIDTH+1  redirect target

## Operation
- Circular buffer; head/tail pointers ROB+1 bits wrapping modulo DEPTH; count register $clog2(DEPTH+1) bits.
- Allocation: alloc_valid && alloc_ready writes {dest, isBranch, ready=0, mispredict=0} at tail; tail+1, count+1. alloc_ready = (count != DEPTH), from registered count only (a same-cycle retire does not free space for that cycle's allocation).
- CDB: cdb_valid sets ready, value, mispredict, target of entry cdb_tag at the edge. Writes to unallocated tags are ignored.
- Retire select (combinational): lane i valid iff lanes 0..i-1 valid, entry head+i allocated (i < count), ready set, and no earlier lane mispredicted. First mispredicted lane retires, asserts flush, flush_pc = its target; later lanes suppressed.
- At edge: head += popcount(commit_valid), count adjusted by allocations minus retirements.
- Flush edge: all entries invalidated, head = tail = count = 0; allocation in flush cycle dropped (alloc_ready forced 0 while flush).
- Read ports: valid/value of entry rob1/rob2; CDB bypass — cdb_valid && cdb_tag match gives valid=1, value=cdb_result same cycle.

## Timing
- Reset: head, tail, count = 0; all ready bits 0; commit_valid = 0, flush = 0, flush_pc = 0, alloc_ready = 1, alloc_tag = 0, valid1/valid2 = 0.
- Allocation to earliest retire: 1 cycle after CDB write (CDB at edge n, commit_valid high during cycle n+1).
- CDB write to head entry is not retired in the same cycle as the broadcast (retirement uses registered ready bits only).
- Retirement outputs combinational from registered state; consumers sample at next edge.
- Reset mid-operation: state cleared immediately, outputs at reset values.

## Structure
- Package rob_pkg: rob_entry_t struct {ready, mispredict, isBranch, dest, value, target}, tag type, COMMIT_W default.
- Sub-module commit_select: combinational lane-valid/flush priority chain over COMMIT_W entries starting at head.

## Test plan
- Reset then allocate 8 entries: alloc_tag 0..7, alloc_ready drops after 8th; 9th request ignored.
- Allocate 3, CDB completes tags 2,1,0 in successive cycles: nothing retires until tag 0 ready, then lanes 0,1 retire tags 0,1, next cycle tag 2.
- Head not ready, tag 1 ready: commit_valid = 00 (in-order enforced).
- Tags 0 (ready) and 1 (branch, mispredict, target 0x0000_0400) ready: lanes 0,1 retire, flush=1, flush_pc=0x400; next cycle count=0, alloc_tag=0.
- Read rob1=3 while CDB broadcasts tag 3 value 0xDEADBEEF: valid1=1, ROBValue1=0xDEADBEEF same cycle.
- Head/tail wrap: 20 alloc/retire pairs with DEPTH=8; tags wrap 7→0, no lost or duplicate commits.
